// File: rtl/menu_sequencer.sv
// -----------------------------------------------------------------------------
// menu_sequencer
//
// Game front-end sequencer: a cursor-driven menu, a frame-timed countdown
// ("3, 2, 1, START") and a run state that lasts until the game logic reports
// game over. It also draws the highlight bar behind the selected menu item.
//
// Configuration macro:
//   MENU_WRAP_EN  defined   -> cursor wraps (up at 0 -> last, down at last -> 0)
//                 undefined -> cursor saturates at both ends
//
// Ports:
//   pixel_clk            in   pixel clock, the only clock
//   reset                in   asynchronous, active-low reset
//   frame_tick           in   one-cycle pulse per video frame
//   btn_up/down/select/back in debounced button levels
//   game_over            in   one-cycle pulse from game logic
//   display_enable       in   VGA active-area flag
//   pixel_x, pixel_y     in   current pixel coordinates (10 bits)
//   menu_active          out  high in MENU
//   countdown_active     out  high in COUNTDOWN
//   countdown_value      out  current countdown number, 0 shows "START"
//   sel_index            out  selected item, 0..NUM_ITEMS-1
//   game_start           out  one-cycle pulse as play begins
//   highlight_visible    out  highlight-bar pixel flag (1 cycle latency)
//   highlight_color_332  out  RGB332 bar colour, 0 when not visible
// -----------------------------------------------------------------------------
module menu_sequencer #(
  parameter int         NUM_ITEMS       = 2,
  parameter int         COUNT_FROM      = 3,
  parameter int         FRAMES_PER_STEP = 60,
  parameter logic [9:0] ITEM_Y0         = 10'd200,
  parameter logic [9:0] ITEM_PITCH      = 10'd20,
  parameter logic [9:0] ITEM_H          = 10'd16,
  parameter logic [9:0] BAR_X0          = 10'd240,
  parameter logic [9:0] BAR_X1          = 10'd400,
  parameter logic [7:0] COLOR_BAR       = 8'b010_010_10
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic       game_over,
  input  logic       display_enable,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       menu_active,
  output logic       countdown_active,
  output logic [7:0] countdown_value,
  output logic [2:0] sel_index,
  output logic       game_start,
  output logic       highlight_visible,
  output logic [7:0] highlight_color_332
);

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    COUNTDOWN = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ITEM  = 3'(NUM_ITEMS - 1);
  localparam logic [7:0] COUNT_INIT = 8'(COUNT_FROM);
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

  state_t     state_q, state_d;
  logic       menu_active_d, countdown_active_d, game_start_d;

  logic       up_q, down_q, select_q, back_q;
  logic       armed_q;
  logic       up_ev, down_ev, select_ev, back_ev;
  logic [7:0] frame_cnt_q;
  logic       step_expire;

  logic [9:0] row_top, row_end;
  logic       bar_hit;

  // ---------------------------------------------------------------------------
  // Button edge detection. armed_q stays low for the first cycle after reset
  // so the history registers can catch up with buttons that were already held
  // through reset; otherwise such a button would look like a fresh press.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      select_q <= 1'b0;
      back_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      up_q     <= btn_up;
      down_q   <= btn_down;
      select_q <= btn_select;
      back_q   <= btn_back;
      armed_q  <= 1'b1;
    end
  end

  assign up_ev     = armed_q & btn_up     & ~up_q;
  assign down_ev   = armed_q & btn_down   & ~down_q;
  assign select_ev = armed_q & btn_select & ~select_q;
  assign back_ev   = armed_q & btn_back   & ~back_q;

  assign step_expire = frame_tick && (frame_cnt_q == LAST_FRAME);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) state_q <= MENU;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is given a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MENU:      if (select_ev) state_d = COUNTDOWN;
      COUNTDOWN: begin
        // back wins over a simultaneous final step expiry
        if (back_ev)                                   state_d = MENU;
        else if (step_expire && countdown_value == '0) state_d = RUN;
      end
      RUN:       if (game_over) state_d = MENU;
      default:   state_d = MENU;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic, decoded from the next state and registered below so
  // the status outputs change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    menu_active_d      = (state_d == MENU);
    countdown_active_d = (state_d == COUNTDOWN);
    game_start_d       = (state_q == COUNTDOWN) && (state_d == RUN);
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      menu_active      <= 1'b1;
      countdown_active <= 1'b0;
      game_start       <= 1'b0;
    end else begin
      menu_active      <= menu_active_d;
      countdown_active <= countdown_active_d;
      game_start       <= game_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: cursor, countdown value and frame counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      sel_index       <= '0;
      countdown_value <= COUNT_INIT;
      frame_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        MENU: begin
          if (select_ev) begin
            // select takes priority; the cursor stays where it is
            countdown_value <= COUNT_INIT;
            frame_cnt_q     <= '0;
          end else if (up_ev && !down_ev) begin
`ifdef MENU_WRAP_EN
            sel_index <= (sel_index == '0) ? LAST_ITEM : sel_index - 3'd1;
`else
            if (sel_index != '0) sel_index <= sel_index - 3'd1;
`endif
          end else if (down_ev && !up_ev) begin
`ifdef MENU_WRAP_EN
            sel_index <= (sel_index == LAST_ITEM) ? '0 : sel_index + 3'd1;
`else
            if (sel_index != LAST_ITEM) sel_index <= sel_index + 3'd1;
`endif
          end
        end
        COUNTDOWN: begin
          if (back_ev) begin
            countdown_value <= COUNT_INIT;
            frame_cnt_q     <= '0;
          end else if (step_expire) begin
            frame_cnt_q <= '0;
            // at 0 the expiry starts the game instead of decrementing
            if (countdown_value != '0) countdown_value <= countdown_value - 8'd1;
          end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (game_over) begin
            countdown_value <= COUNT_INIT;
            frame_cnt_q     <= '0;
          end
        end
        default: begin
          countdown_value <= COUNT_INIT;
          frame_cnt_q     <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Highlight bar: rectangle behind the selected item, registered once.
  // ---------------------------------------------------------------------------
  always_comb begin
    row_top = ITEM_Y0 + ({7'd0, sel_index} * ITEM_PITCH);
    row_end = row_top + ITEM_H;
    bar_hit = menu_active && display_enable &&
              (pixel_x >= BAR_X0) && (pixel_x < BAR_X1) &&
              (pixel_y >= row_top) && (pixel_y < row_end);
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      highlight_visible   <= 1'b0;
      highlight_color_332 <= 8'h00;
    end else begin
      highlight_visible   <= bar_hit;
      highlight_color_332 <= bar_hit ? COLOR_BAR : 8'h00;
    end
  end

endmodule

// File: tb/tb_menu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_menu_sequencer
//
// Directed bench for menu_sequencer with NUM_ITEMS=4, COUNT_FROM=3,
// FRAMES_PER_STEP=2 and default bar geometry. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the output is
// compared. Cursor expectations follow MENU_WRAP_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_menu_sequencer;

  logic       pixel_clk;
  logic       reset;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_select, btn_back;
  logic       game_over;
  logic       display_enable;
  logic [9:0] pixel_x, pixel_y;
  logic       menu_active;
  logic       countdown_active;
  logic [7:0] countdown_value;
  logic [2:0] sel_index;
  logic       game_start;
  logic       highlight_visible;
  logic [7:0] highlight_color_332;

  menu_sequencer #(
    .NUM_ITEMS      (4),
    .COUNT_FROM     (3),
    .FRAMES_PER_STEP(2)
  ) dut (
    .pixel_clk          (pixel_clk),
    .reset              (reset),
    .frame_tick         (frame_tick),
    .btn_up             (btn_up),
    .btn_down           (btn_down),
    .btn_select         (btn_select),
    .btn_back           (btn_back),
    .game_over          (game_over),
    .display_enable     (display_enable),
    .pixel_x            (pixel_x),
    .pixel_y            (pixel_y),
    .menu_active        (menu_active),
    .countdown_active   (countdown_active),
    .countdown_value    (countdown_value),
    .sel_index          (sel_index),
    .game_start         (game_start),
    .highlight_visible  (highlight_visible),
    .highlight_color_332(highlight_color_332)
  );

  initial pixel_clk = 1'b0;
  always #20 pixel_clk = ~pixel_clk;

  localparam logic [7:0] BAR_COLOR = 8'h4A;  // 010_010_10

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   gs_count = 0;

  // Counts clock cycles in which game_start is high.
  always @(posedge pixel_clk) if (game_start === 1'b1) gs_count++;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=%0h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  // One-cycle button press followed by one idle cycle.
  task automatic press(input int which);
    case (which)
      0: btn_up     = 1'b1;
      1: btn_down   = 1'b1;
      2: btn_select = 1'b1;
      default: btn_back = 1'b1;
    endcase
    step();
    btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0; btn_back = 1'b0;
    step();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    push({pfx, "_menu"}, 32'd1);        check(32'(menu_active));
    push({pfx, "_cd_active"}, 32'd0);   check(32'(countdown_active));
    push({pfx, "_cd_value"}, 32'd3);    check(32'(countdown_value));
    push({pfx, "_sel"}, 32'd0);         check(32'(sel_index));
    push({pfx, "_game_start"}, 32'd0);  check(32'(game_start));
    push({pfx, "_hl_vis"}, 32'd0);      check(32'(highlight_visible));
    push({pfx, "_hl_col"}, 32'd0);      check(32'(highlight_color_332));
  endtask

  initial begin
    int exp_cd[8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    int gs_before;
    logic vis;

    reset = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0; btn_back = 1'b0;
    display_enable = 1'b0; pixel_x = '0; pixel_y = '0;

    // ---- reset state ----
    step(); step();
    check_reset_state("rst");
    reset = 1'b1;
    step(); step();

    // ---- cursor: three downs then one more at the last item ----
    press(1); push("down1", 32'd1); check(32'(sel_index));
    press(1); push("down2", 32'd2); check(32'(sel_index));
    press(1); push("down3", 32'd3); check(32'(sel_index));
    press(1);
`ifdef MENU_WRAP_EN
    push("down_at_last", 32'd0); check(32'(sel_index));
    press(1);
`else
    push("down_at_last", 32'd3); check(32'(sel_index));
    press(0); press(0);
`endif
    push("cursor_to_1", 32'd1); check(32'(sel_index));

    // ---- simultaneous up and down: no movement ----
    btn_up = 1'b1; btn_down = 1'b1;
    step();
    btn_up = 1'b0; btn_down = 1'b0;
    step();
    push("up_down_same_cycle", 32'd1); check(32'(sel_index));

    // ---- highlight sweep, item 1 occupies rows 220..235 ----
    display_enable = 1'b1;
    pixel_x = 10'd300;
    for (int y = 219; y <= 237; y++) begin
      pixel_y = 10'(y);
      vis = (y >= 220) && (y <= 235);
      step();
      push($sformatf("hl_vis_y%0d", y), 32'(vis));
      check(32'(highlight_visible));
      push($sformatf("hl_col_y%0d", y), vis ? 32'(BAR_COLOR) : 32'd0);
      check(32'(highlight_color_332));
    end
    pixel_y = 10'd225;
    pixel_x = 10'd240; step(); push("hl_x_left_edge", 32'd1);  check(32'(highlight_visible));
    pixel_x = 10'd399; step(); push("hl_x_right_in", 32'd1);   check(32'(highlight_visible));
    pixel_x = 10'd400; step(); push("hl_x_right_out", 32'd0);  check(32'(highlight_visible));
    pixel_x = 10'd300; display_enable = 1'b0;
    step(); push("hl_blanking", 32'd0); check(32'(highlight_visible));

    // ---- select together with down: countdown, cursor unchanged ----
    btn_select = 1'b1; btn_down = 1'b1;
    step();
    btn_down = 1'b0;
    push("sel_down_cd_active", 32'd1); check(32'(countdown_active));
    push("sel_down_menu", 32'd0);      check(32'(menu_active));
    push("sel_down_sel", 32'd1);       check(32'(sel_index));
    push("sel_down_cd_value", 32'd3);  check(32'(countdown_value));
    for (int i = 0; i < 100; i++) step();   // select still held
    btn_select = 1'b0;
    step();
    push("held_select_cd_active", 32'd1); check(32'(countdown_active));
    push("held_select_cd_value", 32'd3);  check(32'(countdown_value));

    // ---- back after 3 ticks ----
    run_ticks(3);
    push("three_ticks_value", 32'd2); check(32'(countdown_value));
    press(3);
    push("back_menu", 32'd1);     check(32'(menu_active));
    push("back_cd_active", 32'd0); check(32'(countdown_active));
    push("back_cd_value", 32'd3); check(32'(countdown_value));

    // ---- full countdown to RUN ----
    gs_before = gs_count;
    press(2);
    for (int i = 0; i < 8; i++) begin
      push($sformatf("cd_value_tick%0d", i + 1), 32'(exp_cd[i]));
      check(32'(countdown_value));
      push($sformatf("no_start_before_tick%0d", i + 1), 32'd0);
      check(32'(game_start));
      run_ticks(1);
    end
    push("game_start_pulse", 32'd1); check(32'(game_start));
    push("run_cd_active", 32'd0);    check(32'(countdown_active));
    push("run_menu", 32'd0);         check(32'(menu_active));
    step();
    push("game_start_drop", 32'd0);  check(32'(game_start));
    push("single_start_pulse", 32'(gs_before + 1)); check(32'(gs_count));

    // ---- back ignored in RUN, game_over returns to MENU ----
    press(3);
    push("run_back_ignored", 32'd0); check(32'(menu_active));
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    push("over_menu", 32'd1);     check(32'(menu_active));
    push("over_cd_value", 32'd3); check(32'(countdown_value));
    push("over_sel_kept", 32'd1); check(32'(sel_index));

    // ---- second run, then reset during RUN ----
    press(2);
    run_ticks(8);
    step();
    push("second_run", 32'd0); check(32'(menu_active));
    gs_before = gs_count;
    reset = 1'b0;
    #1;
    check_reset_state("rst_run");
    btn_down = 1'b1;               // held across reset release
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    push("held_button_no_event", 32'd0); check(32'(sel_index));
    btn_down = 1'b0;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    step();
    check_reset_state("post_reset");
    push("no_start_after_reset", 32'(gs_before)); check(32'(gs_count));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/menu_sequencer.md
MENU_SEQUENCER -- requirements
Module: menu_sequencer

Interface
REQ-001 Parameter NUM_ITEMS, default 2, is the number of selectable menu items; legal range 2..8.
REQ-002 Parameter COUNT_FROM, default 3, is the first countdown value shown; legal range 1..9.
REQ-003 Parameter FRAMES_PER_STEP, default 60, is the number of frame_tick pulses per countdown step; legal range 1..255.
REQ-004 Parameters ITEM_Y0 (200), ITEM_PITCH (20), ITEM_H (16), BAR_X0 (240), BAR_X1 (400), all 10-bit, set the geometry of the highlight bar.
REQ-005 Parameter COLOR_BAR, default 8'b010_010_10, is the RGB332 highlight colour.
REQ-006 pixel_clk  in  1  25 MHz pixel clock; the only clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 frame_tick  in  1  one-cycle pulse once per video frame.
REQ-009 btn_up, btn_down, btn_select, btn_back  in  1 each  debounced level inputs.
REQ-010 game_over  in  1  one-cycle pulse from game logic.
REQ-011 display_enable  in  1  VGA active-area flag.
REQ-012 pixel_x, pixel_y  in  10 each  current pixel coordinates.
REQ-013 menu_active  out  1  high in state MENU.
REQ-014 countdown_active  out  1  high in state COUNTDOWN.
REQ-015 countdown_value  out  8  current countdown number; 0 means "START".
REQ-016 sel_index  out  3  selected item index, 0..NUM_ITEMS-1.
REQ-017 game_start  out  1  one-cycle pulse when play begins.
REQ-018 highlight_visible, highlight_color_332  out  1, 8  highlight-bar pixel flag and colour.

Function
REQ-019 FSM states: MENU, COUNTDOWN, RUN; all outputs are registered.
REQ-020 Each button is rising-edge detected against a registered copy of itself; a held button produces exactly one event.
REQ-021 MENU: an up event decrements sel_index and a down event increments it; simultaneous up and down events in the same cycle leave sel_index unchanged.
REQ-022 MENU: a select event enters COUNTDOWN on the next cycle, loads countdown_value=COUNT_FROM and clears the 8-bit frame counter; a select in the same cycle as up/down takes priority and sel_index does not move.
REQ-023 COUNTDOWN: each frame_tick increments the frame counter; when a tick arrives with the counter at FRAMES_PER_STEP-1, the counter clears and countdown_value decrements by 1.
REQ-024 COUNTDOWN: when the step expiry of REQ-023 occurs with countdown_value=0, the FSM enters RUN and game_start pulses high for exactly that one transition cycle.
REQ-025 COUNTDOWN: a back event returns to MENU on the next cycle, restores countdown_value=COUNT_FROM and clears the frame counter; back has priority over a simultaneous step expiry.
REQ-026 RUN: game_over returns to MENU with countdown_value=COUNT_FROM; back is ignored in RUN.
REQ-027 sel_index is frozen outside MENU; up, down and select events outside MENU are discarded.
REQ-028 highlight_visible is 1 when, one cycle after sampling the inputs, all of the following held: menu_active=1, display_enable=1, BAR_X0<=pixel_x<BAR_X1, and ITEM_Y0+sel_index*ITEM_PITCH <= pixel_y < ITEM_Y0+sel_index*ITEM_PITCH+ITEM_H; latency is 1 pixel_clk.
REQ-029 highlight_color_332 equals COLOR_BAR when highlight_visible=1, otherwise 8'h00.
REQ-030 Row arithmetic uses 10-bit unsigned values; the parameters are constrained so that no row exceeds 479.

Reset
REQ-031 While reset=0 the block is in state MENU with menu_active=1, countdown_active=0, countdown_value=COUNT_FROM, sel_index=0, game_start=0, highlight_visible=0, highlight_color_332=8'h00, frame counter 0, and button history registers 0.
REQ-032 An asserted reset mid-COUNTDOWN or mid-RUN aborts immediately, with no game_start pulse; after release, a button already held high produces no event.

Configuration
REQ-033 With macro MENU_WRAP_EN defined, the cursor wraps: up at 0 goes to NUM_ITEMS-1 and down at NUM_ITEMS-1 goes to 0.
REQ-034 Without MENU_WRAP_EN, the cursor saturates: up at 0 and down at NUM_ITEMS-1 leave sel_index unchanged.

Verification
REQ-035 NUM_ITEMS=4: press down three times, then down once more -> sel_index reads 1,2,3,3 without the macro and 1,2,3,0 with MENU_WRAP_EN.
REQ-036 FRAMES_PER_STEP=2, COUNT_FROM=3: select, then 8 frame_ticks -> countdown_value 3,3,2,2,1,1,0,0, then RUN with a single game_start pulse on the 8th tick.
REQ-037 Press back after 3 ticks of a countdown -> MENU, countdown_value=3, and the next select restarts the full 8-tick sequence.
REQ-038 Select and down rising together in MENU -> COUNTDOWN entered with sel_index unchanged; holding select for 100 cycles -> only one transition.
REQ-039 sel_index=1 with defaults; sweep pixel_y 219..237 at pixel_x=300 -> highlight_visible is 1 exactly for y=220..235, one cycle late, with colour 8'b010_010_10.
REQ-040 Assert reset during RUN, then pulse game_over -> outputs match REQ-031 and no game_start pulse is seen.
